// File: rtl/instruction_encoder.sv
// Purpose : packs decoded RV32I fields into 32-bit instruction words and writes them
//           to consecutive instruction-memory addresses (program loader).
// Latency : one cycle from accepted bundle to mem_we/mem_addr/mem_wdata; one word per cycle.
// Backpr. : in_ready is high only in LOAD; it drops the cycle after the last or DEPTH-th word.
// Ports   : clk, reset_n (async, active-low), start (restart pulse),
//           in_valid/in_ready + field bundle (opcode, rd, rs1, rs2, funct3, funct7, imm, last),
//           mem_we/mem_addr/mem_wdata (write port), instr_count, busy, done, full, bad_opcode.
module instruction_encoder #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6:0]            opcode,
   input  logic [4:0]            rd,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic [31:0]           imm,
   input  logic                  last,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [ADDR_WIDTH:0]   instr_count,
   output logic                  busy,
   output logic                  done,
   output logic                  full,
   output logic                  bad_opcode
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2,
      S_FULL = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic                  r_bad;

   logic                  w_fire;
   logic                  w_legal;
   logic                  w_at_cap;
   logic [31:0]           w_word;

   // start wins over a same-cycle handshake, so the bundle is dropped.
   assign in_ready = (r_state == S_LOAD) && (r_count < DEPTH);
   assign w_fire   = in_valid && in_ready && !start;
   assign w_at_cap = (r_count == LAST_SLOT);

   // Field packing per opcode format; unknown opcodes are flagged illegal.
   always_comb begin
      w_word  = 32'd0;
      w_legal = 1'b1;
      case (opcode)
         OP_R:
            w_word = {funct7, rs2, rs1, funct3, rd, opcode};
         OP_IMM, OP_LOAD, OP_JALR: begin
            // Shift-immediates carry funct7 in the upper immediate bits.
            if (opcode == OP_IMM && funct3[1:0] == 2'b01)
               w_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            else
               w_word = {imm[11:0], rs1, funct3, rd, opcode};
         end
         OP_STORE:
            w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         OP_BRANCH:
            w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         OP_LUI, OP_AUIPC:
            w_word = {imm[31:12], rd, opcode};
         OP_JAL:
            w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default:
            w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = (r_state == S_LOAD);
      done   = (r_state == S_DONE) || (r_state == S_FULL);
      full   = (r_state == S_FULL);
      if (start)
         w_next = S_LOAD;
      else if (w_fire) begin
         // An illegal opcode tagged last still terminates the program.
         if (last)
            w_next = S_DONE;
         else if (w_legal && w_at_cap)
            w_next = S_FULL;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_bad   <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (start) begin
            r_count <= '0;
            r_bad   <= 1'b0;
         end else if (w_fire) begin
            if (w_legal) begin
               r_we    <= 1'b1;
               r_addr  <= r_count[ADDR_WIDTH-1:0];
               r_wdata <= w_word;
               r_count <= r_count + ONE;
            end else begin
               r_bad <= 1'b1;
            end
         end
      end
   end

   assign mem_we      = r_we;
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign instr_count = r_count;
   assign bad_opcode  = r_bad;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0, in_valid = 1'b0, last = 1'b0;
   logic [6:0]  opcode = '0, funct7 = '0;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] imm = '0;

   logic        in_ready, mem_we, busy, done, full, bad_opcode;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [8:0]  instr_count;

   // Small-capacity instance shares the field inputs.
   logic        s_start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
   logic        s_ready, s_we, s_busy, s_done, s_full, s_bad;
   logic [1:0]  s_addr;
   logic [31:0] s_wdata;
   logic [2:0]  s_count;

   int n_tests = 0;
   int n_fail  = 0;
   int step    = 0;

   // Behavioural model state
   int m_count = 0;
   bit m_load = 0, m_done = 0, m_full = 0, m_bad = 0;

   logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

   instruction_encoder #(.ADDR_WIDTH(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
      .imm(imm), .last(last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .instr_count(instr_count), .busy(busy), .done(done), .full(full), .bad_opcode(bad_opcode)
   );

   instruction_encoder #(.ADDR_WIDTH(2)) u_small (
      .clk(clk), .reset_n(reset_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
      .imm(imm), .last(s_last), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
      .instr_count(s_count), .busy(s_busy), .done(s_done), .full(s_full), .bad_opcode(s_bad)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s (step %0d): observed %0h, expected %0h", tag, step, obs, exp);
      end
   endtask

   // Reference encoding built from field positions with plain arithmetic.
   function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [4:0] rd_i,
         input logic [4:0] rs1_i, input logic [4:0] rs2_i, input logic [2:0] f3_i,
         input logic [6:0] f7_i, input logic [31:0] imm_i, output bit ok);
      int unsigned o, d, a, b, f3, f7, im, w;
      o = op; d = rd_i; a = rs1_i; b = rs2_i; f3 = f3_i; f7 = f7_i; im = imm_i;
      ok = 1;
      w  = 0;
      case (o)
         'h33: w = f7 * (1 << 25) + b * (1 << 20) + a * (1 << 15) + f3 * (1 << 12) + d * 128 + o;
         'h13, 'h03, 'h67: begin
            if (o == 'h13 && (f3 == 1 || f3 == 5))
               w = f7 * (1 << 25) + (im % 32) * (1 << 20);
            else
               w = (im % 4096) * (1 << 20);
            w = w + a * (1 << 15) + f3 * (1 << 12) + d * 128 + o;
         end
         'h23: w = ((im / 32) % 128) * (1 << 25) + b * (1 << 20) + a * (1 << 15)
                   + f3 * (1 << 12) + (im % 32) * 128 + o;
         'h63: w = ((im >> 12) % 2) * (1 << 31) + ((im >> 5) % 64) * (1 << 25) + b * (1 << 20)
                   + a * (1 << 15) + f3 * (1 << 12) + ((im >> 1) % 16) * 256
                   + ((im >> 11) % 2) * 128 + o;
         'h37, 'h17: w = (im / 4096) * 4096 + d * 128 + o;
         'h6F: w = ((im >> 20) % 2) * (1 << 31) + ((im >> 1) % 1024) * (1 << 21)
                   + ((im >> 11) % 2) * (1 << 20) + ((im >> 12) % 256) * (1 << 12) + d * 128 + o;
         default: ok = 0;
      endcase
      return w;
   endfunction

   // One clock of the big instance: drive, predict, clock, compare.
   task automatic cycle(input bit st, input bit v, input logic [6:0] op, input logic [4:0] rd_i,
         input logic [4:0] rs1_i, input logic [4:0] rs2_i, input logic [2:0] f3_i,
         input logic [6:0] f7_i, input logic [31:0] imm_i, input bit lst);
      bit ok, acc, exp_we;
      logic [31:0] exp_word;
      int exp_addr;
      step++;
      start = st; in_valid = v; opcode = op; rd = rd_i; rs1 = rs1_i; rs2 = rs2_i;
      funct3 = f3_i; funct7 = f7_i; imm = imm_i; last = lst;
      exp_word = ref_encode(op, rd_i, rs1_i, rs2_i, f3_i, f7_i, imm_i, ok);
      acc = v && m_load && !st;
      exp_we = 0;
      exp_addr = 0;
      if (st) begin
         m_count = 0; m_bad = 0; m_load = 1; m_done = 0; m_full = 0;
      end else if (acc) begin
         if (ok) begin
            exp_we = 1; exp_addr = m_count; m_count++;
         end else
            m_bad = 1;
         if (lst) begin
            m_load = 0; m_done = 1;
         end else if (ok && m_count == 256) begin
            m_load = 0; m_done = 1; m_full = 1;
         end
      end
      @(posedge clk);
      #1;
      chk("mem_we", mem_we, exp_we);
      if (exp_we) begin
         chk("mem_addr", mem_addr, exp_addr);
         chk("mem_wdata", mem_wdata, exp_word);
      end
      chk("instr_count", instr_count, m_count);
      chk("bad_opcode", bad_opcode, m_bad);
      chk("done", done, m_done);
      chk("full", full, m_full);
      chk("busy", busy, m_load);
      chk("in_ready", in_ready, m_load);
      start = 0; in_valid = 0; last = 0;
   endtask

   task automatic do_start();
      cycle(1, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic idle();
      cycle(0, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] rd_i, input logic [4:0] rs1_i,
         input logic [4:0] rs2_i, input logic [2:0] f3_i, input logic [6:0] f7_i,
         input logic [31:0] imm_i, input bit lst);
      cycle(0, 1, op, rd_i, rs1_i, rs2_i, f3_i, f7_i, imm_i, lst);
   endtask

   task automatic send_random(input bit allow_bad);
      int idx;
      logic [6:0] op;
      idx = $urandom_range(0, allow_bad ? 9 : 8);
      op  = (idx == 9) ? 7'h7F : ops[idx];
      cycle(0, ($urandom_range(0, 3) != 0), op, 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), $urandom, 0);
   endtask

   task automatic chk_reset();
      chk("rst in_ready", in_ready, 0);
      chk("rst mem_we", mem_we, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      chk("rst instr_count", instr_count, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst full", full, 0);
      chk("rst bad_opcode", bad_opcode, 0);
   endtask

   initial begin
      bit ok;
      logic [31:0] w;

      // Reset state
      #12;
      chk_reset();
      chk("rst s_full", s_full, 0);
      @(negedge clk);
      reset_n = 1;

      // IDLE ignores a bundle
      send(7'h33, 3, 1, 2, 0, 0, 0, 0);

      // Single R-type
      do_start();
      send(7'h33, 3, 1, 2, 0, 0, 0, 0);
      chk("r_type word", mem_wdata, 32'h002081B3);

      // Mixed stream ending with last
      do_start();
      send(7'h13, 1, 0, 0, 0, 0, 5, 0);
      chk("addi word", mem_wdata, 32'h00500093);
      send(7'h23, 0, 1, 2, 3'b010, 0, 8, 0);
      chk("sw word", mem_wdata, 32'h0020A423);
      send(7'h63, 0, 0, 0, 0, 0, 8, 0);
      chk("beq word", mem_wdata, 32'h00000463);
      send(7'h6F, 1, 0, 0, 0, 0, 16, 0);
      chk("jal word", mem_wdata, 32'h010000EF);
      send(7'h37, 5, 0, 0, 0, 0, 32'h12345000, 1);
      chk("lui word", mem_wdata, 32'h123452B7);
      chk("lui addr", mem_addr, 4);
      idle();
      chk("stream count", instr_count, 5);
      send(7'h33, 1, 1, 1, 0, 0, 0, 0);

      // Shift immediates
      do_start();
      send(7'h13, 1, 1, 0, 3'b001, 7'b0000000, 3, 0);
      chk("slli word", mem_wdata, 32'h00309093);
      send(7'h13, 1, 1, 0, 3'b101, 7'b0100000, 3, 0);
      chk("srai word", mem_wdata, 32'h4030D093);

      // Unsupported opcode mid-stream, sticky flag
      send(7'h7F, 1, 1, 1, 0, 0, 0, 0);
      send(7'h13, 2, 0, 0, 0, 0, 7, 0);
      chk("addr after bad", mem_addr, 2);
      idle();
      do_start();
      send(7'h7F, 1, 1, 1, 0, 0, 0, 1);
      chk("bad last done", done, 1);

      // Randomised stream
      do_start();
      for (int i = 0; i < 60; i++) send_random(1);
      send(7'h17, 9, 0, 0, 0, 0, $urandom, 1);
      idle();

      // Fill to capacity without last
      do_start();
      for (int i = 0; i < 256; i++)
         cycle(0, 1, ops[$urandom_range(0, 8)], 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 7'($urandom), $urandom, 0);
      send(7'h33, 1, 1, 1, 0, 0, 0, 0);
      chk("full count", instr_count, 256);

      // start in same cycle as a handshake drops the bundle
      do_start();
      cycle(1, 1, 7'h33, 1, 2, 3, 0, 0, 0, 0);
      chk("start drop count", instr_count, 0);

      // Asynchronous reset right after an accept
      in_valid = 1; opcode = 7'h13; rd = 1; imm = 1; last = 0;
      @(posedge clk);
      reset_n = 0;
      in_valid = 0;
      #1;
      step++;
      chk_reset();
      m_count = 0; m_load = 0; m_done = 0; m_full = 0; m_bad = 0;
      @(posedge clk);
      #1;
      chk("rst held mem_we", mem_we, 0);
      reset_n = 1;
      idle();

      // Small instance: four words fill it
      s_start = 1;
      @(posedge clk); #1;
      s_start = 0;
      chk("s busy", s_busy, 1);
      for (int i = 0; i < 4; i++) begin
         s_valid = 1; opcode = 7'h13; rd = 5'(i + 1); rs1 = 0; funct3 = 0; imm = 32'(i * 3);
         w = ref_encode(7'h13, 5'(i + 1), 0, 0, 0, 0, 32'(i * 3), ok);
         @(posedge clk); #1;
         chk("s we", s_we, 1);
         chk("s addr", s_addr, i);
         chk("s wdata", s_wdata, w);
         chk("s count", s_count, i + 1);
      end
      chk("s full", s_full, 1);
      chk("s done", s_done, 1);
      chk("s ready", s_ready, 0);
      @(posedge clk); #1;
      chk("s fifth we", s_we, 0);
      chk("s fifth count", s_count, 4);
      s_valid = 0;
      s_start = 1;
      @(posedge clk); #1;
      s_start = 0;
      chk("s restart busy", s_busy, 1);
      chk("s restart count", s_count, 0);
      chk("s restart full", s_full, 0);
      chk("s restart ready", s_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
